// File: rtl/decode_stage.sv
// RV32I decode pipeline register feeding the ALU: decodes OP / OP-IMM / LUI / AUIPC
// into registered ALU operands behind a valid/ready handshake with synchronous flush.
module decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_in_valid,
  output logic            o_in_ready,
  input  logic [31:0]     i_inst,
  input  logic [XLEN-1:0] i_pc,
  output logic [4:0]      o_rs1_addr,
  output logic [4:0]      o_rs2_addr,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic            i_flush,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  output logic [XLEN-1:0] o_aluin1,
  output logic [XLEN-1:0] o_aluin2,
  output logic [2:0]      o_funct3,
  output logic            o_funct7,
  output logic [4:0]      o_rd,
  output logic            o_rd_we,
  output logic            o_illegal
);

  typedef enum logic [0:0] {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] F7_ZERO   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_load;
  logic [6:0]        w_opcode;
  logic [6:0]        w_f7_field;
  logic [2:0]        w_f3_field;
  logic [XLEN-1:0]   w_aluin1;
  logic [XLEN-1:0]   w_aluin2;
  logic [2:0]        w_funct3;
  logic              w_funct7;
  logic              w_illegal;
  logic [XLEN-1:0]   r_aluin1;
  logic [XLEN-1:0]   r_aluin2;
  logic [2:0]        r_funct3;
  logic              r_funct7;
  logic [4:0]        r_rd;
  logic              r_rd_we;
  logic              r_illegal;

  assign o_in_ready = (r_state == ST_EMPTY) || i_out_ready;
  assign w_load     = i_in_valid && o_in_ready && !i_flush;
  assign o_rs1_addr = i_inst[19:15];
  assign o_rs2_addr = i_inst[24:20];
  assign w_opcode   = i_inst[6:0];
  assign w_f7_field = i_inst[31:25];
  assign w_f3_field = i_inst[14:12];

  // Occupancy state register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Occupancy next state; flush overrides both load and hold
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: begin
        if (w_load) w_state_nxt = ST_FULL;
        else        w_state_nxt = ST_EMPTY;
      end
      ST_FULL: begin
        if (i_out_ready && !w_load) w_state_nxt = ST_EMPTY;
        else                        w_state_nxt = ST_FULL;
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
    if (i_flush) w_state_nxt = ST_EMPTY;
    else         w_state_nxt = w_state_nxt;
  end

  // Instruction decode into ALU operands and legality
  always_comb begin
    w_aluin1  = {XLEN{1'b0}};
    w_aluin2  = {XLEN{1'b0}};
    w_funct3  = 3'b000;
    w_funct7  = 1'b0;
    w_illegal = 1'b0;
    case (w_opcode)
      OPC_OP: begin
        w_aluin1 = i_rs1_data;
        w_aluin2 = i_rs2_data;
        w_funct3 = w_f3_field;
        w_funct7 = i_inst[30];
        if ((w_f7_field != F7_ZERO) && (w_f7_field != F7_ALT)) begin
          w_illegal = 1'b1;
        end else if ((w_f7_field == F7_ALT) && (w_f3_field != 3'b000) && (w_f3_field != 3'b101)) begin
          w_illegal = 1'b1;
        end else begin
          w_illegal = 1'b0;
        end
      end
      OPC_OPIMM: begin
        w_aluin1 = i_rs1_data;
        w_funct3 = w_f3_field;
        if ((w_f3_field == 3'b001) || (w_f3_field == 3'b101)) begin
          w_aluin2 = {{(XLEN-5){1'b0}}, i_inst[24:20]};
          w_funct7 = (w_f3_field == 3'b101) ? i_inst[30] : 1'b0;
          if ((w_f7_field != F7_ZERO) && (w_f7_field != F7_ALT)) begin
            w_illegal = 1'b1;
          end else if ((w_f7_field == F7_ALT) && (w_f3_field == 3'b001)) begin
            w_illegal = 1'b1;
          end else begin
            w_illegal = 1'b0;
          end
        end else begin
          // funct7 forced low so a negative ADDI immediate never selects SUB
          w_aluin2 = {{(XLEN-12){i_inst[31]}}, i_inst[31:20]};
          w_funct7 = 1'b0;
        end
      end
      OPC_LUI: begin
        w_aluin2 = {i_inst[31:12], 12'h000};
      end
      OPC_AUIPC: begin
        w_aluin1 = i_pc;
        w_aluin2 = {i_inst[31:12], 12'h000};
      end
      default: begin
        w_illegal = 1'b1;
      end
    endcase
  end

  // Output register; updates only on load, cleared by reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_aluin1  <= {XLEN{1'b0}};
      r_aluin2  <= {XLEN{1'b0}};
      r_funct3  <= 3'b000;
      r_funct7  <= 1'b0;
      r_rd      <= 5'd0;
      r_rd_we   <= 1'b0;
      r_illegal <= 1'b0;
    end else if (w_load) begin
      r_aluin1  <= w_aluin1;
      r_aluin2  <= w_aluin2;
      r_funct3  <= w_funct3;
      r_funct7  <= w_funct7;
      r_rd      <= i_inst[11:7];
      r_rd_we   <= !w_illegal && (i_inst[11:7] != 5'd0);
      r_illegal <= w_illegal;
    end else begin
      r_aluin1  <= r_aluin1;
      r_aluin2  <= r_aluin2;
      r_funct3  <= r_funct3;
      r_funct7  <= r_funct7;
      r_rd      <= r_rd;
      r_rd_we   <= r_rd_we;
      r_illegal <= r_illegal;
    end
  end

  assign o_out_valid = (r_state == ST_FULL);
  assign o_aluin1    = r_aluin1;
  assign o_aluin2    = r_aluin2;
  assign o_funct3    = r_funct3;
  assign o_funct7    = r_funct7;
  assign o_rd        = r_rd;
  assign o_rd_we     = r_rd_we;
  assign o_illegal   = r_illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: expected decodes are queued when a load is driven
// and popped when the stage presents them; held values are re-checked while stalled.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] inst, pc, rs1_data, rs2_data, aluin1, aluin2;
  logic [4:0]  rs1_addr, rs2_addr, rd;
  logic [2:0]  funct3;
  logic        funct7, rd_we, illegal;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32)) dut (
    .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_inst(inst), .i_pc(pc), .o_rs1_addr(rs1_addr), .o_rs2_addr(rs2_addr),
    .i_rs1_data(rs1_data), .i_rs2_data(rs2_data), .i_flush(flush),
    .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_aluin1(aluin1), .o_aluin2(aluin2), .o_funct3(funct3), .o_funct7(funct7),
    .o_rd(rd), .o_rd_we(rd_we), .o_illegal(illegal)
  );

  typedef struct packed {
    logic [31:0] a1;
    logic [31:0] a2;
    logic [2:0]  f3;
    logic        f7;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  exp_t held;
  exp_t nil;
  logic m_valid;
  int   passed = 0;
  int   total  = 0;
  int   failed = 0;

  function automatic exp_t mk(input logic [31:0] a1, input logic [31:0] a2, input logic [2:0] f3,
                              input logic f7, input logic [4:0] r, input logic we, input logic ill);
    exp_t e;
    e.a1 = a1; e.a2 = a2; e.f3 = f3; e.f7 = f7; e.rd = r; e.we = we; e.ill = ill;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  task automatic chk_outputs(input string tag, input exp_t e);
    chk({tag, ".aluin1"},  aluin1, e.a1);
    chk({tag, ".aluin2"},  aluin2, e.a2);
    chk({tag, ".funct3"},  {29'd0, funct3}, {29'd0, e.f3});
    chk({tag, ".funct7"},  {31'd0, funct7}, {31'd0, e.f7});
    chk({tag, ".rd"},      {27'd0, rd}, {27'd0, e.rd});
    chk({tag, ".rd_we"},   {31'd0, rd_we}, {31'd0, e.we});
    chk({tag, ".illegal"}, {31'd0, illegal}, {31'd0, e.ill});
  endtask

  // One clock: drive inputs, check handshake, advance, then check what the stage holds.
  task automatic step(input string tag, input logic [31:0] i_w, input logic [31:0] p,
                      input logic [31:0] d1, input logic [31:0] d2, input logic v,
                      input logic ordy, input logic fl, input logic r, input exp_t e);
    logic ld;
    exp_t got;
    inst = i_w; pc = p; rs1_data = d1; rs2_data = d2;
    in_valid = v; out_ready = ordy; flush = fl; rst = r;
    #1;
    chk({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, (!m_valid || ordy)});
    chk({tag, ".rs1_addr"}, {27'd0, rs1_addr}, {27'd0, i_w[19:15]});
    chk({tag, ".rs2_addr"}, {27'd0, rs2_addr}, {27'd0, i_w[24:20]});
    ld = v && (!m_valid || ordy) && !fl && !r;
    if (ld) sb.push_back(e);
    else    ld = 1'b0;
    @(posedge clk);
    #1;
    if (r)       begin m_valid = 1'b0; held = nil; sb.delete(); end
    else if (fl) m_valid = 1'b0;
    else if (ld) m_valid = 1'b1;
    else if (ordy) m_valid = 1'b0;
    chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, m_valid});
    if (ld && !r) begin
      total++;
      if (sb.size() == 0) begin
        failed++;
        $error("FAIL %s.scoreboard observed=empty expected=entry", tag);
      end else begin
        passed++;
        got  = sb.pop_front();
        held = got;
      end
    end
    if (m_valid || r) chk_outputs(tag, held);
  endtask

  initial begin
    nil = mk(32'd0, 32'd0, 3'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    held = nil;
    m_valid = 1'b0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    inst = 32'd0; pc = 32'd0; rs1_data = 32'd0; rs2_data = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.out_valid", {31'd0, out_valid}, 32'd0);
    chk_outputs("reset", nil);

    // test-plan sequence, back to back with consumer always ready
    step("addi", 32'hFFF10093, 32'h0, 32'd7, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0,
         mk(32'd7, 32'hFFFFFFFF, 3'b000, 1'b0, 5'd1, 1'b1, 1'b0));
    step("sub", 32'h402081B3, 32'h4, 32'd7, 32'd10, 1'b1, 1'b1, 1'b0, 1'b0,
         mk(32'd7, 32'd10, 3'b000, 1'b1, 5'd3, 1'b1, 1'b0));
    step("srai", 32'h40335293, 32'h8, 32'h80000007, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0,
         mk(32'h80000007, 32'd3, 3'b101, 1'b1, 5'd5, 1'b1, 1'b0));
    step("srli", 32'h01F1D113, 32'hC, 32'h55, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0,
         mk(32'h55, 32'd31, 3'b101, 1'b0, 5'd2, 1'b1, 1'b0));
    step("slli_alt", 32'h40209093, 32'h10, 32'h9, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0,
         mk(32'h9, 32'd2, 3'b001, 1'b0, 5'd1, 1'b0, 1'b1));
    step("and_alt", 32'h4062F233, 32'h14, 32'h11, 32'h22, 1'b1, 1'b1, 1'b0, 1'b0,
         mk(32'h11, 32'h22, 3'b111, 1'b1, 5'd4, 1'b0, 1'b1));
    step("addi_x0", 32'h00500013, 32'h18, 32'h3, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0,
         mk(32'h3, 32'd5, 3'b000, 1'b0, 5'd0, 1'b0, 1'b0));
    step("zero_inst", 32'h00000000, 32'h1C, 32'h7, 32'h8, 1'b1, 1'b1, 1'b0, 1'b0,
         mk(32'd0, 32'd0, 3'b000, 1'b0, 5'd0, 1'b0, 1'b1));
    step("lui", 32'h123453B7, 32'h20, 32'hAA, 32'hBB, 1'b1, 1'b1, 1'b0, 1'b0,
         mk(32'd0, 32'h12345000, 3'b000, 1'b0, 5'd7, 1'b1, 1'b0));

    // stall three cycles with AUIPC pending, then release: it loads as LUI is consumed
    for (int k = 0; k < 3; k++) begin
      step("stall", 32'h00001397, 32'h100, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, nil);
    end
    step("auipc", 32'h00001397, 32'h100, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0,
         mk(32'h100, 32'h00001000, 3'b000, 1'b0, 5'd7, 1'b1, 1'b0));

    // drain, then idle with empty stage
    step("drain", 32'h0, 32'h0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, nil);
    step("idle", 32'h0, 32'h0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, nil);

    // flush beats a simultaneous load
    step("flush_load", 32'hFFF10093, 32'h0, 32'd1, 32'd0, 1'b1, 1'b1, 1'b1, 1'b0, nil);

    // flush beats a hold
    step("load_for_flush", 32'h402081B3, 32'h0, 32'd5, 32'd6, 1'b1, 1'b0, 1'b0, 1'b0,
         mk(32'd5, 32'd6, 3'b000, 1'b1, 5'd3, 1'b1, 1'b0));
    step("flush_hold", 32'h0, 32'h0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, nil);

    // reset while stalled clears every registered output
    step("load_for_rst", 32'h40335293, 32'h0, 32'h80000007, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0,
         mk(32'h80000007, 32'd3, 3'b101, 1'b1, 5'd5, 1'b1, 1'b0));
    step("stall_pre_rst", 32'hFFF10093, 32'h0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, nil);
    step("rst_mid_stall", 32'hFFF10093, 32'h0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 1'b1, nil);
    step("post_rst", 32'hFFF10093, 32'h0, 32'd7, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0,
         mk(32'd7, 32'hFFFFFFFF, 3'b000, 1'b0, 5'd1, 1'b1, 1'b0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
